// File: rtl/mem_rsp_pkg.sv
// Shared types and sizing for the RAM read-response buffer.
// Default geometry: 4-bit address, 32-bit data, 4 response entries.
package mem_rsp_pkg;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_DEPTH  = 4;
    localparam int CNT_W      = $clog2(MEM_DEPTH) + 1;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Generic synchronous FIFO with a registered head output (dout shows the oldest entry).
// Push while full is accepted only when a pop frees a slot in the same cycle.
module mem_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CW-1:0]    w_count_nxt;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_dout;

    assign w_pop        = pop && !empty;
    assign w_push       = push && (!full || w_pop);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
    assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Head register: takes the incoming word when it lands in the slot that becomes the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_count_nxt != '0) begin
                r_dout <= (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? din : r_mem[w_rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/mem_rsp_buffer.sv
// In-order read-response buffer: tags RAM responses with their read address and issues read credit.
// Optional MEM_RSP_BUF_STATS_EN adds drop_cnt (saturating drop counter) and peak_cnt (max fill level).
module mem_rsp_buffer
    import mem_rsp_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH = MEM_DATA_W,
    parameter int DEPTH      = MEM_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_fire,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    output logic                    req_ready,
    input  logic                    mem_valid,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [ADDR_WIDTH-1:0]   rsp_addr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err_overflow,
    output logic                    err_orphan
`ifdef MEM_RSP_BUF_STATS_EN
    ,
    output logic [15:0]             drop_cnt,
    output logic [CNT_W-1:0]        peak_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  w_tag_push;
    logic                  w_tag_pop;
    logic                  w_tag_full;
    logic                  w_tag_empty;
    logic [CW-1:0]         w_tag_count;
    logic [ADDR_WIDTH-1:0] w_tag_head;

    logic                  w_rsp_push;
    logic                  w_rsp_pop;
    logic                  w_rsp_full;
    logic                  w_rsp_empty;
    logic [CW-1:0]         w_rsp_count;
    rsp_entry_t            w_rsp_in;
    rsp_entry_t            w_rsp_head;

    logic                  w_orphan;
    logic                  w_overflow;
    logic [CW:0]           w_credit_used;

    logic                  r_err_overflow;
    logic                  r_err_orphan;

    // Credit counts both buffered entries and reads still in flight, so every response has a slot.
    assign w_credit_used = {1'b0, w_rsp_count} + {1'b0, w_tag_count};
    assign req_ready     = (w_credit_used < (CW+1)'(DEPTH));

    assign w_tag_push = req_fire && req_ready && !w_tag_full;
    assign w_orphan   = mem_valid && w_tag_empty;
    assign w_tag_pop  = mem_valid && !w_tag_empty;
    assign w_rsp_pop  = rsp_valid && rsp_ready;
    assign w_rsp_push = w_tag_pop && (!w_rsp_full || w_rsp_pop);
    assign w_overflow = w_tag_pop && w_rsp_full && !w_rsp_pop;

    assign w_rsp_in.addr = w_tag_head;
    assign w_rsp_in.data = mem_data;

    assign rsp_valid    = !w_rsp_empty;
    assign rsp_data     = w_rsp_head.data;
    assign rsp_addr     = w_rsp_head.addr;
    assign count        = w_rsp_count;
    assign err_overflow = r_err_overflow;
    assign err_orphan   = r_err_orphan;

    mem_rsp_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_tag_push),
        .din   (req_addr),
        .pop   (w_tag_pop),
        .dout  (w_tag_head),
        .full  (w_tag_full),
        .empty (w_tag_empty),
        .count (w_tag_count)
    );

    mem_rsp_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_rsp_push),
        .din   (w_rsp_in),
        .pop   (w_rsp_pop),
        .dout  (w_rsp_head),
        .full  (w_rsp_full),
        .empty (w_rsp_empty),
        .count (w_rsp_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_overflow <= 1'b0;
            r_err_orphan   <= 1'b0;
        end else begin
            r_err_overflow <= r_err_overflow || w_overflow;
            r_err_orphan   <= r_err_orphan || w_orphan;
        end
    end

`ifdef MEM_RSP_BUF_STATS_EN
    logic [15:0]      r_drop_cnt;
    logic [CNT_W-1:0] r_peak_cnt;

    assign drop_cnt = r_drop_cnt;
    assign peak_cnt = r_peak_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
            r_peak_cnt <= '0;
        end else begin
            if ((w_orphan || w_overflow) && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (CNT_W'(w_rsp_count) > r_peak_cnt) begin
                r_peak_cnt <= CNT_W'(w_rsp_count);
            end
        end
    end
`endif

endmodule
